// File: rtl/npu_add_pkg.sv
// rtl/npu_add_pkg.sv - shared types and constants for the INT8 element-wise ADD lane
// Contents: packed quant-set width and 32-bit field offsets, scheduler FSM encoding.
package npu_add_pkg;

    localparam int QCFG_W = 384;
    localparam int QF_W   = 32;

    // Bit offsets of the twelve 32-bit fields inside the packed quant set.
    localparam int QF_IN1_OFF    = 0 * QF_W;
    localparam int QF_IN2_OFF    = 1 * QF_W;
    localparam int QF_LEFT_SHIFT = 2 * QF_W;
    localparam int QF_IN1_MULT   = 3 * QF_W;
    localparam int QF_IN2_MULT   = 4 * QF_W;
    localparam int QF_IN1_SHIFT  = 5 * QF_W;
    localparam int QF_IN2_SHIFT  = 6 * QF_W;
    localparam int QF_OUT_MULT   = 7 * QF_W;
    localparam int QF_OUT_SHIFT  = 8 * QF_W;
    localparam int QF_OUT_OFF    = 9 * QF_W;
    localparam int QF_ACT_MIN    = 10 * QF_W;
    localparam int QF_ACT_MAX    = 11 * QF_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/add_sched_retire.sv
// rtl/add_sched_retire.sv - retire counter, result write-back register and sticky error
// Ports: clk, rst (sync, active-low), clr (job accepted), accept_en (job in ISSUE/DRAIN),
//        len/dst_base (job shadows), add_valid/add_out (ADD results),
//        out_wr_en/out_wr_addr/out_wr_data (write-back), ret_cnt, err.
module add_sched_retire #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept_en,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic              add_valid,
    input  logic [7:0]        add_out,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [7:0]        out_wr_data,
    output logic [LEN_W-1:0]  ret_cnt,
    output logic              err
);

    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [LEN_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic              err_q,     err_d;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ret_cnt_d = ret_cnt_q;
        err_d     = err_q;
        if (clr) begin
            ret_cnt_d = '0;
            err_d     = 1'b0;
        end
        if (add_valid) begin
            // A result is only legal while a job is running and still owes results.
            if (accept_en && (ret_cnt_q != len)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = dst_base + ADDR_W'(ret_cnt_q);
                wr_data_d = add_out;
                ret_cnt_d = ret_cnt_q + LEN_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ret_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ret_cnt_q <= ret_cnt_d;
            err_q     <= err_d;
        end
    end

    assign out_wr_en   = wr_en_q;
    assign out_wr_addr = wr_addr_q;
    assign out_wr_data = wr_data_q;
    assign ret_cnt     = ret_cnt_q;
    assign err         = err_q;

endmodule

// File: rtl/add_elem_scheduler.sv
// rtl/add_elem_scheduler.sv - job sequencer for one INT8 element-wise ADD lane
// Ports: clk, rst (sync, active-low); job request start/len/src1_base/src2_base/dst_base/cfg_quant;
//        status busy/done/err; operand SRAM reads mem1_*/mem2_*; ADD pipeline add_input_valid/
//        add_in1/add_in2/add_quant/add_out/add_valid; result write out_wr_*.
// Option: ADD_SCHED_BROADCAST_EN adds bcast2, which reads operand 2 once in LOAD and reuses it.
module add_elem_scheduler
    import npu_add_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 16,
    parameter int ADD_LAT = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] src1_base,
    input  logic [ADDR_W-1:0] src2_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [QCFG_W-1:0] cfg_quant,
`ifdef ADD_SCHED_BROADCAST_EN
    input  logic              bcast2,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem1_rd_en,
    output logic [ADDR_W-1:0] mem1_rd_addr,
    input  logic [7:0]        mem1_rd_data,
    output logic              mem2_rd_en,
    output logic [ADDR_W-1:0] mem2_rd_addr,
    input  logic [7:0]        mem2_rd_data,
    output logic              add_input_valid,
    output logic [7:0]        add_in1,
    output logic [7:0]        add_in2,
    output logic [QCFG_W-1:0] add_quant,
    input  logic [7:0]        add_out,
    input  logic              add_valid,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [7:0]        out_wr_data
);

    sched_state_t      state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [QCFG_W-1:0] quant_q, quant_d;
    logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic              aiv_q, aiv_d;
    logic [LEN_W-1:0]  ret_cnt;
    logic              job_accept;
    logic              issuing;
    logic [7:0]        in2_src;

`ifdef ADD_SCHED_BROADCAST_EN
    logic              bcast_q, bcast_d;
    logic              bcast_rd_q, bcast_rd_d;
    logic [7:0]        bcast_byte_q, bcast_byte_d;
`endif

    assign job_accept = (state_q == ST_IDLE) && start;
    assign issuing    = (state_q == ST_ISSUE);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dst_d       = dst_q;
        quant_d     = quant_q;
        issue_cnt_d = issue_cnt_q;
        aiv_d       = issuing;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    len_d       = len;
                    src1_d      = src1_base;
                    src2_d      = src2_base;
                    dst_d       = dst_base;
                    quant_d     = cfg_quant;
                    issue_cnt_d = '0;
                end
            end
            ST_LOAD:  state_d = (len_q == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: begin
                issue_cnt_d = issue_cnt_q + LEN_W'(1);
                if (issue_cnt_d == len_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (ret_cnt == len_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef ADD_SCHED_BROADCAST_EN
    // The broadcast byte is read in LOAD and lands one cycle later, before the first issue.
    always_comb begin
        bcast_d      = job_accept ? bcast2 : bcast_q;
        bcast_rd_d   = (state_q == ST_LOAD) && bcast_q;
        bcast_byte_d = bcast_rd_q ? mem2_rd_data : bcast_byte_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcast_q      <= 1'b0;
            bcast_rd_q   <= 1'b0;
            bcast_byte_q <= '0;
        end else begin
            bcast_q      <= bcast_d;
            bcast_rd_q   <= bcast_rd_d;
            bcast_byte_q <= bcast_byte_d;
        end
    end

    assign mem2_rd_en = bcast_q ? (state_q == ST_LOAD) : issuing;
    assign in2_src    = bcast_q ? bcast_byte_q : mem2_rd_data;
`else
    assign mem2_rd_en = issuing;
    assign in2_src    = mem2_rd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dst_q       <= '0;
            quant_q     <= '0;
            issue_cnt_q <= '0;
            aiv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dst_q       <= dst_d;
            quant_q     <= quant_d;
            issue_cnt_q <= issue_cnt_d;
            aiv_q       <= aiv_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign mem1_rd_en   = issuing;
    assign mem1_rd_addr = src1_q + ADDR_W'(issue_cnt_q);
    // issue_cnt is still 0 in LOAD, so this also addresses the broadcast read.
    assign mem2_rd_addr = src2_q + ADDR_W'(issue_cnt_q);

    // SRAM data is valid exactly in the cycle after the read, which is when aiv_q is high.
    assign add_input_valid = aiv_q;
    assign add_in1         = aiv_q ? mem1_rd_data : 8'h00;
    assign add_in2         = aiv_q ? in2_src : 8'h00;
    assign add_quant       = quant_q;

    add_sched_retire #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_retire (
        .clk         (clk),
        .rst         (rst),
        .clr         (job_accept),
        .accept_en   ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)),
        .len         (len_q),
        .dst_base    (dst_q),
        .add_valid   (add_valid),
        .add_out     (add_out),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .out_wr_data (out_wr_data),
        .ret_cnt     (ret_cnt),
        .err         (err)
    );

endmodule

// File: tb/tb_add_elem_scheduler.sv
// tb/tb_add_elem_scheduler.sv - scoreboard bench for add_elem_scheduler with stub SRAMs and ADD pipe
module tb_add_elem_scheduler;
    import npu_add_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 16;
    localparam int ADD_LAT = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [ADDR_W-1:0] src1_base = '0, src2_base = '0, dst_base = '0;
    logic [QCFG_W-1:0] cfg_quant = '0;
`ifdef ADD_SCHED_BROADCAST_EN
    logic              bcast2 = 1'b0;
`endif
    logic              busy, done, err;
    logic              mem1_rd_en, mem2_rd_en;
    logic [ADDR_W-1:0] mem1_rd_addr, mem2_rd_addr;
    logic [7:0]        mem1_rd_data, mem2_rd_data;
    logic              add_input_valid;
    logic [7:0]        add_in1, add_in2;
    logic [QCFG_W-1:0] add_quant;
    logic [7:0]        add_out;
    logic              add_valid;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [7:0]        out_wr_data;

    always #5 clk = ~clk;

    add_elem_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .src1_base(src1_base), .src2_base(src2_base), .dst_base(dst_base), .cfg_quant(cfg_quant),
`ifdef ADD_SCHED_BROADCAST_EN
        .bcast2(bcast2),
`endif
        .busy(busy), .done(done), .err(err),
        .mem1_rd_en(mem1_rd_en), .mem1_rd_addr(mem1_rd_addr), .mem1_rd_data(mem1_rd_data),
        .mem2_rd_en(mem2_rd_en), .mem2_rd_addr(mem2_rd_addr), .mem2_rd_data(mem2_rd_data),
        .add_input_valid(add_input_valid), .add_in1(add_in1), .add_in2(add_in2),
        .add_quant(add_quant), .add_out(add_out), .add_valid(add_valid),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    // Stub byte SRAMs with one-cycle read latency.
    logic [7:0] mem1 [65536];
    logic [7:0] mem2 [65536];
    always @(posedge clk) begin
        if (mem1_rd_en) mem1_rd_data <= mem1[mem1_rd_addr];
        if (mem2_rd_en) mem2_rd_data <= mem2[mem2_rd_addr];
    end

    // Stub ADD pipeline: in1+in2 after ADD_LAT cycles; not reset, so in-flight work survives rst.
    logic [ADD_LAT-1:0] pv = '0;
    logic [7:0]         pd [ADD_LAT];
    always @(posedge clk) begin
        pv    <= {pv[ADD_LAT-2:0], add_input_valid};
        pd[0] <= add_in1 + add_in2;
        for (int i = 1; i < ADD_LAT; i++) pd[i] <= pd[i-1];
    end
    assign add_valid = pv[ADD_LAT-1];
    assign add_out   = pd[ADD_LAT-1];

    int tests = 0;
    int fails = 0;
    logic [23:0] exp_q [$];
    logic [QCFG_W-1:0] qcfg_pat;
    int r_rd1, r_rd2, r_wr, r_done_n, r_done_k, r_busy, r_aiv_k;

    // Drives one job, pushes its expected writes, and scoreboards writes while it runs.
    // ign_at > 0 pulses a second start with different parameters at that cycle.
    task automatic run_job(input logic [15:0] n, input logic [15:0] s1, input logic [15:0] s2,
                           input logic [15:0] d, input logic bc, input int ign_at);
        logic [15:0] a1, a2, da;
        logic [7:0]  sum;
        logic [23:0] got, expv;
        for (int i = 0; i < int'(n); i++) begin
            a1 = s1 + 16'(i);
            a2 = bc ? s2 : s2 + 16'(i);
            da = d + 16'(i);
            sum = mem1[a1] + mem2[a2];
            exp_q.push_back({da, sum});
        end
        r_rd1 = 0; r_rd2 = 0; r_wr = 0; r_done_n = 0; r_done_k = 0; r_busy = 0; r_aiv_k = 0;
        @(negedge clk);
        start = 1'b1; len = n; src1_base = s1; src2_base = s2; dst_base = d; cfg_quant = qcfg_pat;
`ifdef ADD_SCHED_BROADCAST_EN
        bcast2 = bc;
`endif
        for (int k = 1; k <= int'(n) + ADD_LAT + 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Disturb every job input; the DUT must be working from its shadows now.
                len = 16'd2; src1_base = 16'h7700; src2_base = 16'h7800; dst_base = 16'h5000;
                cfg_quant = ~qcfg_pat;
            end
            start = (k == ign_at);
            if (mem1_rd_en) r_rd1++;
            if (mem2_rd_en) r_rd2++;
            if (busy) r_busy++;
            if (add_input_valid && r_aiv_k == 0) r_aiv_k = k;
            if (done) begin
                r_done_n++;
                if (r_done_k == 0) r_done_k = k;
            end
            if (out_wr_en) begin
                r_wr++;
                tests++;
                got = {out_wr_addr, out_wr_data};
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", out_wr_addr, out_wr_data);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        fails++;
                        $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                                 got[23:8], got[7:0], expv[23:8], expv[7:0]);
                    end
                end
            end
        end
        start = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, err, mem1_rd_en, mem2_rd_en, add_input_valid, out_wr_en} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {busy, done, err, mem1_rd_en, mem2_rd_en, add_input_valid, out_wr_en});
        end
        tests++;
        if (add_quant !== '0 || out_wr_addr !== '0 || out_wr_data !== '0 || mem1_rd_addr !== '0) begin
            fails++;
            $display("FAIL reset_data: got quant_nonzero=%0d wr_addr=%h wr_data=%h rd_addr=%h, required 0",
                     add_quant != '0, out_wr_addr, out_wr_data, mem1_rd_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        for (int i = 0; i < 4; i++) begin
            mem1[16'h0100 + 16'(i)] = 8'(i + 1);
            mem2[16'h0200 + 16'(i)] = 8'(10 * (i + 1));
        end
        run_job(16'd4, 16'h0100, 16'h0200, 16'h0300, 1'b0, 0);
        tests++;
        if (r_done_k !== 4 + ADD_LAT + 4) begin
            fails++; $display("FAIL basic_done_cycle: got %0d, required %0d", r_done_k, 4 + ADD_LAT + 4);
        end
        tests++;
        if (r_aiv_k !== 3) begin
            fails++; $display("FAIL basic_first_issue: got %0d, required 3", r_aiv_k);
        end
        tests++;
        if (r_done_n !== 1 || r_busy !== 18) begin
            fails++; $display("FAIL basic_done_busy: got done=%0d busy=%0d, required done=1 busy=18", r_done_n, r_busy);
        end
        tests++;
        if (r_rd1 !== 4 || r_rd2 !== 4 || r_wr !== 4) begin
            fails++; $display("FAIL basic_counts: got rd1=%0d rd2=%0d wr=%0d, required 4 4 4", r_rd1, r_rd2, r_wr);
        end
        tests++;
        if (add_quant !== qcfg_pat) begin
            fails++; $display("FAIL basic_quant_shadow: got %h, required %h", add_quant[31:0], qcfg_pat[31:0]);
        end
    endtask

    task automatic test_len_zero;
        run_job(16'd0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 0);
        tests++;
        if (r_busy !== 2 || r_done_n !== 1 || r_done_k !== 2) begin
            fails++;
            $display("FAIL len0_timing: got busy=%0d done=%0d at %0d, required busy=2 done=1 at 2", r_busy, r_done_n, r_done_k);
        end
        tests++;
        if (r_rd1 !== 0 || r_rd2 !== 0 || r_wr !== 0) begin
            fails++; $display("FAIL len0_traffic: got rd1=%0d rd2=%0d wr=%0d, required 0 0 0", r_rd1, r_rd2, r_wr);
        end
    endtask

    task automatic test_start_ignored;
        run_job(16'd4, 16'h0100, 16'h0200, 16'h0300, 1'b0, 3);
        tests++;
        if (r_done_k !== 18 || r_done_n !== 1 || r_rd1 !== 4 || r_wr !== 4) begin
            fails++;
            $display("FAIL ignore_start: got done=%0d@%0d rd1=%0d wr=%0d, required 1@18 4 4", r_done_n, r_done_k, r_rd1, r_wr);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) begin
            mem1[16'h0010 + 16'(i)] = 8'($urandom_range(0, 255));
            mem2[16'h0020 + 16'(i)] = 8'($urandom_range(0, 255));
        end
        run_job(16'd4, 16'h0010, 16'h0020, 16'hFFFE, 1'b0, 0);
        tests++;
        if (r_wr !== 4 || r_done_k !== 18) begin
            fails++; $display("FAIL wrap_job: got wr=%0d done@%0d, required 4 @18", r_wr, r_done_k);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] n;
        for (int j = 0; j < 3; j++) begin
            n = 16'($urandom_range(1, 16));
            for (int i = 0; i < 16; i++) begin
                mem1[16'h1000 + 16'(i)] = 8'($urandom_range(0, 255));
                mem2[16'h2000 + 16'(i)] = 8'($urandom_range(0, 255));
            end
            run_job(n, 16'h1000, 16'h2000, 16'h3000 + 16'(j * 32), 1'b0, 0);
            tests++;
            if (r_done_k !== int'(n) + ADD_LAT + 4 || r_wr !== int'(n)) begin
                fails++;
                $display("FAIL b2b_job%0d: got done@%0d wr=%0d, required @%0d wr=%0d", j, r_done_k, r_wr, int'(n) + ADD_LAT + 4, n);
            end
        end
    endtask

    task automatic test_reset_mid_drain;
        int wr_n, done_n;
        @(negedge clk);
        start = 1'b1; len = 16'd4; src1_base = 16'h0100; src2_base = 16'h0200; dst_base = 16'h0300;
        cfg_quant = qcfg_pat;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tests++;
        if ({busy, done, err, mem1_rd_en, mem2_rd_en, add_input_valid, out_wr_en} !== 7'b0 || add_quant !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got %b quant_nonzero=%0d, required 0",
                     {busy, done, err, mem1_rd_en, mem2_rd_en, add_input_valid, out_wr_en}, add_quant != '0);
        end
        wr_n = 0; done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_wr_en) wr_n++;
            if (done) done_n++;
        end
        tests++;
        if (err !== 1'b1 || wr_n !== 0 || done_n !== 0) begin
            fails++; $display("FAIL midreset_late: got err=%b wr=%0d done=%0d, required err=1 0 0", err, wr_n, done_n);
        end
        mem1[16'h0400] = 8'd7;
        mem2[16'h0500] = 8'd9;
        run_job(16'd1, 16'h0400, 16'h0500, 16'h0600, 1'b0, 0);
        tests++;
        if (err !== 1'b0 || r_wr !== 1) begin
            fails++; $display("FAIL midreset_restart: got err=%b wr=%0d, required err=0 wr=1", err, r_wr);
        end
    endtask

`ifdef ADD_SCHED_BROADCAST_EN
    task automatic test_broadcast;
        mem2[16'h0600] = 8'd5;
        for (int i = 0; i < 3; i++) mem1[16'h0700 + 16'(i)] = 8'(i + 1);
        run_job(16'd3, 16'h0700, 16'h0600, 16'h0800, 1'b1, 0);
        tests++;
        if (r_rd2 !== 1 || r_rd1 !== 3 || r_wr !== 3) begin
            fails++; $display("FAIL bcast_counts: got rd2=%0d rd1=%0d wr=%0d, required 1 3 3", r_rd2, r_rd1, r_wr);
        end
        run_job(16'd0, 16'h0700, 16'h0600, 16'h0800, 1'b1, 0);
        tests++;
        if (r_rd2 !== 1 || r_done_n !== 1) begin
            fails++; $display("FAIL bcast_len0: got rd2=%0d done=%0d, required 1 1", r_rd2, r_done_n);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 12; i++) qcfg_pat[i*32 +: 32] = 32'hA5C3_0000 + 32'(i * 17);
        test_reset();
        test_basic();
        test_len_zero();
        test_start_ignored();
        test_wrap();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef ADD_SCHED_BROADCAST_EN
        test_broadcast();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
